// File: rtl/spin_update_pkg.sv
// Shared types and helpers for the spin update sequencer and its flip decision logic.
// Defines the default row count `NUM_ROW when the build does not supply one.
`ifndef NUM_ROW
`define NUM_ROW 4
`endif

package spin_update_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_SWEEP_END,
    S_DONE
  } state_e;

  localparam int NUM_SPINS_DFLT = `NUM_ROW;
  localparam int SUM_SIZE_DFLT  = 12;
  localparam int ROW_W          = $clog2(NUM_SPINS_DFLT);
  localparam int FIELD_W        = SUM_SIZE_DFLT + 1;
  localparam int SEXT_MAX       = 32;

  // Sign-extend the low w bits of v to SEXT_MAX bits.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v, input int w);
    logic [SEXT_MAX-1:0] r;
    logic                sb;
    sb = 1'b0;
    for (int i = 0; i < SEXT_MAX; i++)
      if (i == w - 1) sb = v[i];
    for (int i = 0; i < SEXT_MAX; i++)
      r[i] = (i < w) ? v[i] : sb;
    return r;
  endfunction

endpackage

// File: rtl/spin_update_sequencer_flip_decide.sv
// Combinational flip decision: flip when sum + noise is negative. The sum is formed
// far wider than SUM_SIZE+1 bits, so it never wraps; noise is dropped when NOISE_EN=0.
module spin_flip_decide
  import spin_update_pkg::*;
#(
  parameter int SUM_SIZE    = 12,
  parameter int NOISE_WIDTH = 8,
  parameter bit NOISE_EN    = 1'b0
) (
  input  logic [SUM_SIZE-1:0]    sum_in,
  input  logic [NOISE_WIDTH-1:0] noise_in,
  output logic                   flip
);

  logic [SEXT_MAX-1:0] sum_x;
  logic [SEXT_MAX-1:0] noise_x;

  always_comb begin
    sum_x   = sext(SEXT_MAX'(sum_in), SUM_SIZE);
    noise_x = NOISE_EN ? sext(SEXT_MAX'(noise_in), NOISE_WIDTH) : '0;
    flip    = ($signed(sum_x) + $signed(noise_x)) < 0;
  end

endmodule

// File: rtl/spin_update_sequencer.sv
// Sequential Gauss-Seidel spin update controller feeding the row reduce adder.
// Build macro SPIN_NOISE_EN adds noise_in to the field before the flip decision.
module spin_update_sequencer
  import spin_update_pkg::*;
#(
  parameter int NUM_SPINS     = `NUM_ROW,
  parameter int SUM_SIZE      = 12,
  parameter int ADDER_LATENCY = 0,
  parameter int NOISE_WIDTH   = 8,
  parameter int MAX_SWEEPS    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [NUM_SPINS-1:0]             spins_init,
  input  logic [SUM_SIZE-1:0]              sum_in,
  input  logic [NOISE_WIDTH-1:0]           noise_in,
  output logic [$clog2(NUM_SPINS)-1:0]     row_idx,
  output logic                             current_spin,
  output logic [NUM_SPINS-1:0]             spins,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NUM_SPINS+1)-1:0]   flip_count,
  output logic [$clog2(MAX_SWEEPS+1)-1:0]  sweep_count
);

  localparam int RW  = $clog2(NUM_SPINS);
  localparam int FCW = $clog2(NUM_SPINS + 1);
  localparam int SCW = $clog2(MAX_SWEEPS + 1);
  localparam int LW  = (ADDER_LATENCY > 1) ? $clog2(ADDER_LATENCY) : 1;

`ifdef SPIN_NOISE_EN
  localparam bit NOISE_EN = 1'b1;
`else
  localparam bit NOISE_EN = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [NUM_SPINS-1:0] spins_q, spins_d;
  logic [FCW-1:0] flips_q, flips_d;
  logic [FCW-1:0] flip_count_q, flip_count_d;
  logic [SCW-1:0] sweep_count_q, sweep_count_d;
  logic [RW-1:0]  row_idx_q, row_idx_d;
  logic           cur_spin_q, cur_spin_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           flip;
  logic           last_sweep;

  spin_flip_decide #(
    .SUM_SIZE   (SUM_SIZE),
    .NOISE_WIDTH(NOISE_WIDTH),
    .NOISE_EN   (NOISE_EN)
  ) u_decide (
    .sum_in  (sum_in),
    .noise_in(noise_in),
    .flip    (flip)
  );

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    lat_d         = lat_q;
    spins_d       = spins_q;
    flips_d       = flips_q;
    flip_count_d  = flip_count_q;
    sweep_count_d = sweep_count_q;
    row_idx_d     = row_idx_q;
    cur_spin_d    = cur_spin_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    last_sweep    = (flips_q == '0) || (sweep_count_q == SCW'(MAX_SWEEPS - 1));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          spins_d       = spins_init;
          row_d         = '0;
          sweep_count_d = '0;
          flips_d       = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Operand select is frozen here and held until the row commits.
        row_idx_d  = row_q;
        cur_spin_d = spins_q[row_q];
        busy_d     = 1'b1;
        lat_d      = '0;
        state_d    = (ADDER_LATENCY == 0) ? S_COMMIT : S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LW'(ADDER_LATENCY - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (flip) begin
          spins_d[row_q] = ~spins_q[row_q];
          flips_d        = flips_q + 1'b1;
        end
        if (row_q == RW'(NUM_SPINS - 1)) begin
          state_d = S_SWEEP_END;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_SWEEP_END: begin
        flip_count_d  = flips_q;
        sweep_count_d = sweep_count_q + 1'b1;
        flips_d       = '0;
        row_d         = '0;
        if (last_sweep) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      lat_q         <= '0;
      spins_q       <= '0;
      flips_q       <= '0;
      flip_count_q  <= '0;
      sweep_count_q <= '0;
      row_idx_q     <= '0;
      cur_spin_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      lat_q         <= lat_d;
      spins_q       <= spins_d;
      flips_q       <= flips_d;
      flip_count_q  <= flip_count_d;
      sweep_count_q <= sweep_count_d;
      row_idx_q     <= row_idx_d;
      cur_spin_q    <= cur_spin_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign row_idx      = row_idx_q;
  assign current_spin = cur_spin_q;
  assign spins        = spins_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign flip_count   = flip_count_q;
  assign sweep_count  = sweep_count_q;

endmodule
